// File: rtl/data_memory_responder.sv
// Responder end of the byte-lane memory interface: registered 4-byte reads every cycle,
// and byte/half/word stores committed one byte per cycle with a done pulse and error status.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write,
    input  logic [7:0]  d3,
    input  logic [7:0]  d2,
    input  logic [7:0]  d1,
    input  logic [7:0]  d0,
    output logic [7:0]  q3,
    output logic [7:0]  q2,
    output logic [7:0]  q1,
    output logic [7:0]  q0,
    output logic        done,
    output logic        error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [3:0][7:0]         r_lanes;
    logic [1:0]              r_last;
    logic [1:0]              r_cnt;
    logic                    r_done;
    logic                    r_error;
    logic [7:0]              r_q3;
    logic [7:0]              r_q2;
    logic [7:0]              r_q1;
    logic [7:0]              r_q0;

    logic [ADDR_WIDTH-1:0]   w_rd_a0;
    logic [ADDR_WIDTH-1:0]   w_rd_a1;
    logic [ADDR_WIDTH-1:0]   w_rd_a2;
    logic [ADDR_WIDTH-1:0]   w_rd_a3;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [7:0]              w_wr_byte;
    logic                    w_wr_en;
    logic [1:0]              w_size_last;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_reject;
    logic                    w_accept;

    // Read addresses wrap modulo the array depth.
    assign w_rd_a0 = address[ADDR_WIDTH-1:0];
    assign w_rd_a1 = w_rd_a0 + {{(ADDR_WIDTH-2){1'b0}}, 2'd1};
    assign w_rd_a2 = w_rd_a0 + {{(ADDR_WIDTH-2){1'b0}}, 2'd2};
    assign w_rd_a3 = w_rd_a0 + {{(ADDR_WIDTH-2){1'b0}}, 2'd3};

    assign w_wr_addr = r_base + {{(ADDR_WIDTH-2){1'b0}}, r_cnt};
    assign w_wr_byte = r_lanes[r_cnt];
    assign w_wr_en   = (r_state == S_WRITE);

    assign w_misaligned   = ((write == 2'b10) && address[0]) ||
                            ((write == 2'b11) && (address[1:0] != 2'b00));
    assign w_out_of_range = |address[31:ADDR_WIDTH];
    assign w_reject       = w_misaligned || w_out_of_range;

    // Index of the final byte for the requested store size.
    always_comb begin
        w_size_last = 2'd0;
        case (write)
            2'b01:   w_size_last = 2'd0;
            2'b10:   w_size_last = 2'd1;
            2'b11:   w_size_last = 2'd3;
            default: w_size_last = 2'd0;
        endcase
    end

    // Store sequencing: next state and accept strobe.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (write != 2'b00) begin
                    w_accept     = 1'b1;
                    w_next_state = w_reject ? S_DONE : S_WRITE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE: begin
                if (r_cnt == r_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            S_DONE: begin
                w_next_state = S_RELEASE;
            end
            S_RELEASE: begin
                // A code still held after done must not start a second store.
                if (write == 2'b00) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RELEASE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, latched request, byte counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= {ADDR_WIDTH{1'b0}};
            r_lanes <= 32'h0000_0000;
            r_last  <= 2'd0;
            r_cnt   <= 2'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_base  <= address[ADDR_WIDTH-1:0];
                r_lanes <= {d0, d1, d2, d3};
                r_last  <= w_size_last;
                r_cnt   <= 2'd0;
                r_error <= w_reject;
            end else if (w_wr_en) begin
                r_cnt   <= r_cnt + 2'd1;
            end else begin
                r_cnt   <= r_cnt;
            end
        end
    end

    // Byte array commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_byte;
        end
    end

    // Registered read lanes; same-edge writes are seen one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q3 <= 8'h00;
            r_q2 <= 8'h00;
            r_q1 <= 8'h00;
            r_q0 <= 8'h00;
        end else begin
            r_q3 <= r_mem[w_rd_a0];
            r_q2 <= r_mem[w_rd_a1];
            r_q1 <= r_mem[w_rd_a2];
            r_q0 <= r_mem[w_rd_a3];
        end
    end

    assign q3    = r_q3;
    assign q2    = r_q2;
    assign q1    = r_q1;
    assign q0    = r_q0;
    assign done  = r_done;
    assign error = r_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a table of store/readback records plus
// hand-written sequences for reset mid-store and a store whose code changes mid-flight.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [1:0]  write;
    logic [7:0]  d3, d2, d1, d0;
    logic [7:0]  q3, q2, q1, q0;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_responder #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .address(address), .write(write),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .q3(q3), .q2(q2), .q1(q1), .q0(q0),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  wr;
        logic [31:0] data;
        logic        err;
        int          cyc;
        logic [31:0] raddr;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] data);
        d3 = data[7:0];
        d2 = data[15:8];
        d1 = data[23:16];
        d0 = data[31:24];
    endtask

    // Counts falling edges until done is seen; -1 if the budget runs out.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_store(input int idx, input logic [31:0] addr, input logic [1:0] wr,
                            input logic [31:0] data, input logic exp_err, input int exp_cyc);
        int cyc;
        @(negedge clk);
        address = addr;
        write   = wr;
        set_data(data);
        wait_done(cyc);
        check($sformatf("store%0d latency", idx), cyc, exp_cyc);
        check($sformatf("store%0d error", idx), {31'd0, error}, {31'd0, exp_err});
        set_data(~data);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("store%0d held done", idx), {31'd0, done}, 32'd0);
        end
        check($sformatf("store%0d error persists", idx), {31'd0, error}, {31'd0, exp_err});
        write = 2'b00;
        @(negedge clk);
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        address = addr;
        write   = 2'b00;
        @(negedge clk);
        check(name, {q0, q1, q2, q3}, exp);
    endtask

    initial begin
        int cyc;
        // {addr, write, data, error, falling edges to done, read addr, read {q0,q1,q2,q3}}
        vecs[0]  = '{32'h0000_0010, 2'b11, 32'h4433_2211, 1'b0, 5, 32'h0000_0010, 32'h4433_2211};
        vecs[1]  = '{32'h0000_0020, 2'b11, 32'hDEAD_BEEF, 1'b0, 5, 32'h0000_0020, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0023, 2'b01, 32'h0000_005A, 1'b0, 2, 32'h0000_0020, 32'h5AAD_BEEF};
        vecs[3]  = '{32'h0000_0022, 2'b10, 32'h0000_1234, 1'b0, 3, 32'h0000_0020, 32'h1234_BEEF};
        vecs[4]  = '{32'h0000_0021, 2'b10, 32'h0000_FFFF, 1'b1, 1, 32'h0000_0020, 32'h1234_BEEF};
        vecs[5]  = '{32'h0000_0024, 2'b11, 32'h0102_0304, 1'b0, 5, 32'h0000_0022, 32'h0304_1234};
        vecs[6]  = '{32'h0000_0FFC, 2'b11, 32'hA1B2_C3D4, 1'b0, 5, 32'h0000_0FFC, 32'hA1B2_C3D4};
        vecs[7]  = '{32'h0000_0000, 2'b11, 32'h5566_7788, 1'b0, 5, 32'h0000_0FFE, 32'h7788_A1B2};
        vecs[8]  = '{32'h0000_1000, 2'b01, 32'h0000_0099, 1'b1, 1, 32'h0000_0000, 32'h5566_7788};
        vecs[9]  = '{32'h8000_0000, 2'b01, 32'h0000_0099, 1'b1, 1, 32'h0000_0000, 32'h5566_7788};
        vecs[10] = '{32'h0000_0002, 2'b10, 32'h0000_CAFE, 1'b0, 3, 32'h0000_0000, 32'hCAFE_7788};
        vecs[11] = '{32'h0000_0012, 2'b11, 32'h9999_9999, 1'b1, 1, 32'h0000_0010, 32'h4433_2211};
        vecs[12] = '{32'h0000_0040, 2'b11, 32'hAAAA_AAAA, 1'b0, 5, 32'h0000_0040, 32'hAAAA_AAAA};

        rst = 1'b1;
        address = 32'd0;
        write = 2'b00;
        set_data(32'd0);
        repeat (3) @(negedge clk);
        check("reset q", {q0, q1, q2, q3}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 13; v++) begin
            do_store(v, vecs[v].addr, vecs[v].wr, vecs[v].data, vecs[v].err, vecs[v].cyc);
            do_read($sformatf("read%0d", v), vecs[v].raddr, vecs[v].rexp);
        end

        // Reset after two bytes of a word store: only those bytes land.
        @(negedge clk);
        address = 32'h0000_0040;
        write   = 2'b11;
        set_data(32'h1122_3344);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        write = 2'b00;
        #1;
        check("midreset q", {q0, q1, q2, q3}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_read("midreset partial", 32'h0000_0040, 32'hAAAA_3344);
        do_store(100, 32'h0000_0043, 2'b01, 32'h0000_005C, 1'b0, 2);
        do_read("post reset store", 32'h0000_0040, 32'h5CAA_3344);

        // Code, address and data change mid-store: the latched word completes.
        @(negedge clk);
        address = 32'h0000_0050;
        write   = 2'b11;
        set_data(32'h0102_0304);
        @(negedge clk);
        @(negedge clk);
        address = 32'h0000_0060;
        write   = 2'b01;
        set_data(32'hFFFF_FFFF);
        wait_done(cyc);
        check("midchange latency", (cyc < 0) ? cyc : cyc + 2, 5);
        check("midchange error", {31'd0, error}, 32'd0);
        @(negedge clk);
        write = 2'b00;
        @(negedge clk);
        do_read("midchange data", 32'h0000_0050, 32'h0102_0304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
